// File: rtl/nxs_pkg.sv
// -----------------------------------------------------------------------------
// nxs_pkg
//  Shared widths, defaults and small helpers for the SK1024 result end.
//  Contents:
//   NXS_NONCE_W      nonce width (64)
//   NXS_HASH_W       width of the final Keccak qword (64)
//   NXS_PIPE_OFFSET  cycles from nonce issue to its hash qword (390)
//   NXS_OVF_W        width of the dropped-hit counter (8)
//   nonce_t/hash_t/ovf_t typedefs, nxsSatInc() saturating increment
//  Optional feature macro used by the top level: NXS_FULL_TARGET_EN
// -----------------------------------------------------------------------------
package nxs_pkg;

    localparam int NXS_NONCE_W     = 64;
    localparam int NXS_HASH_W      = 64;
    localparam int NXS_PIPE_OFFSET = 390;
    localparam int NXS_OVF_W       = 8;

    typedef logic [NXS_NONCE_W-1:0] nonce_t;
    typedef logic [NXS_HASH_W-1:0]  hash_t;
    typedef logic [NXS_OVF_W-1:0]   ovf_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic ovf_t nxsSatInc(input ovf_t value);
        if (value == '1) begin
            return value;
        end
        return value + ovf_t'(1);
    endfunction

endpackage

// File: rtl/nxs_result_fifo.sv
// -----------------------------------------------------------------------------
// nxs_result_fifo
//  Small ring-buffer FIFO for found nonces with a registered show-ahead head:
//  headData always holds the oldest entry as a flop, so the reader sees a
//  stable value that only changes on a pop (or on the first write into an
//  empty FIFO). There is no write-to-read bypass: an entry written into an
//  empty FIFO becomes visible the cycle after the write.
//  Ports:
//   clk        in   clock
//   nHashRst   in   async active-low reset
//   flush      in   synchronous clear of all entries (dominates push/pop)
//   push       in   write pushData (ignored when full, unless popping too)
//   pushData   in   WIDTH  data to write
//   pop        in   discard the head entry (ignored when empty)
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   headData   out  WIDTH  oldest entry, registered
// -----------------------------------------------------------------------------
module nxs_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nHashRst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] headData
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] rdNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cntNext;
    logic [WIDTH-1:0] headReg;
    logic [WIDTH-1:0] headNext;
    logic             doPush;
    logic             doPop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign headData = headReg;

    // A pop on a full FIFO frees the slot the push lands in, so the push is
    // still accepted in that cycle.
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    always_comb begin
        rdNext  = doPop ? rdPtr + PTR_W'(1) : rdPtr;
        cntNext = count;
        unique case ({doPush, doPop})
            2'b10:   cntNext = count + CNT_W'(1);
            2'b01:   cntNext = count - CNT_W'(1);
            default: cntNext = count;
        endcase
    end

    // Next head: the entry at the new read pointer. If that slot is being
    // written in this same cycle the memory still holds the old value, so
    // take the incoming data instead. When the FIFO drains, hold the last
    // head rather than load an unwritten slot.
    always_comb begin
        headNext = headReg;
        if (cntNext != '0) begin
            if (doPush && (wrPtr == rdNext)) begin
                headNext = pushData;
            end else begin
                headNext = mem[rdNext];
            end
        end
    end

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            headReg <= '0;
        end else if (flush) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            headReg <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            rdPtr   <= rdNext;
            count   <= cntNext;
            headReg <= headNext;
        end
    end

    // Storage array without reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (doPush && !flush) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/nxs_nonce_reporter.sv
// -----------------------------------------------------------------------------
// nxs_nonce_reporter
//  Result end of the SK1024 mining pipeline. Issues one nonce per cycle into
//  FirstSkeinRound, pairs each final Keccak qword with the nonce that produced
//  it (issue_nonce - NONCE_OFFSET), flags qwords with ZERO_BITS leading zeros,
//  queues the matching nonces and hands them to the host over valid/ready.
//  Ports:
//   clk           in   pipeline clock
//   nHashRst      in   async active-low reset
//   work_load     in   1-cycle pulse: new work, restart tracking, flush results
//   start_nonce   in   64  first nonce of the new work
//   issue_nonce   out  64  nonce for FirstSkeinRound this cycle
//   hash_qword    in   64  NexusKeccak1024 output qword
//   target        in   64  full target (only used with NXS_FULL_TARGET_EN)
//   res_valid     out  res_nonce holds a found nonce
//   res_ready     in   reader takes res_nonce when res_valid & res_ready
//   res_nonce     out  64  found nonce, already offset-corrected
//   overflow_cnt  out  8   saturating count of hits dropped on a full FIFO
//  Build option: define NXS_FULL_TARGET_EN to also require
//  hash_qword <= target (unsigned) for a hit; otherwise target is ignored.
// -----------------------------------------------------------------------------
module nxs_nonce_reporter
    import nxs_pkg::*;
#(
    parameter int NONCE_OFFSET = NXS_PIPE_OFFSET,
    parameter int ZERO_BITS    = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   nHashRst,
    input  logic                   work_load,
    input  logic [NXS_NONCE_W-1:0] start_nonce,
    output logic [NXS_NONCE_W-1:0] issue_nonce,
    input  logic [NXS_HASH_W-1:0]  hash_qword,
    input  logic [NXS_HASH_W-1:0]  target,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NXS_NONCE_W-1:0] res_nonce,
    output logic [NXS_OVF_W-1:0]   overflow_cnt
);

    localparam int WARM_W = $clog2(NONCE_OFFSET + 1);
    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(NONCE_OFFSET);

    logic [WARM_W-1:0] warmCnt;
    logic              hashValid;
    logic              zeroOk;
    logic              targetOk;
    logic              hitNow;
    nonce_t            candNonce;

    logic              hitReg;
    nonce_t            candReg;
    ovf_t              ovfCnt;

    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPop;
    nonce_t            fifoHead;

    // ---------------------------------------------------------------------
    // Nonce issue counter: reload on new work, otherwise free-running
    // (64-bit wrap is legal).
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            issue_nonce <= '0;
        end else if (work_load) begin
            issue_nonce <= start_nonce;
        end else begin
            issue_nonce <= issue_nonce + nonce_t'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Warm-up counter: the pipeline still holds hashes of nonces from before
    // the reset/load until NONCE_OFFSET cycles have passed, so qwords are
    // only trusted once the counter has saturated.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            warmCnt <= '0;
        end else if (work_load) begin
            warmCnt <= '0;
        end else if (warmCnt != WARM_MAX) begin
            warmCnt <= warmCnt + WARM_W'(1);
        end
    end

    assign hashValid = (warmCnt == WARM_MAX);
    assign zeroOk    = (hash_qword[NXS_HASH_W-1 -: ZERO_BITS] == '0);
    assign candNonce = issue_nonce - nonce_t'(NONCE_OFFSET);

`ifdef NXS_FULL_TARGET_EN
    assign targetOk = (hash_qword <= target);
`else
    // The miner applies the full target in software in this build.
    logic unusedTarget;
    assign unusedTarget = ^target;
    assign targetOk     = 1'b1;
`endif

    // A hit arriving together with new work belongs to the old job.
    assign hitNow = hashValid & zeroOk & targetOk & ~work_load;

    // ---------------------------------------------------------------------
    // Stage 1: registered compare result and its candidate nonce.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            hitReg  <= 1'b0;
            candReg <= '0;
        end else begin
            hitReg  <= hitNow;
            candReg <= candNonce;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: queue the hit, or count it as dropped when there is no room.
    // A pop in the load cycle is ignored because the flush wins anyway.
    // ---------------------------------------------------------------------
    assign fifoPop = res_valid & res_ready & ~work_load;

    nxs_result_fifo #(
        .WIDTH (NXS_NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk      (clk),
        .nHashRst (nHashRst),
        .flush    (work_load),
        .push     (hitReg),
        .pushData (candReg),
        .pop      (fifoPop),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .headData (fifoHead)
    );

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            ovfCnt <= '0;
        end else if (work_load) begin
            ovfCnt <= '0;
        end else if (hitReg && fifoFull && !fifoPop) begin
            ovfCnt <= nxsSatInc(ovfCnt);
        end
    end

    assign res_valid    = ~fifoEmpty;
    assign res_nonce    = fifoHead;
    assign overflow_cnt = ovfCnt;

endmodule

// File: tb/tb_nxs_nonce_reporter.sv
module tb_nxs_nonce_reporter;

    localparam int          OFF   = 390;
    localparam logic [63:0] NOHIT = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        nHashRst;
    logic        work_load;
    logic [63:0] start_nonce;
    logic [63:0] issue_nonce;
    logic [63:0] hash_qword;
    logic [63:0] target;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_nonce;
    logic [7:0]  overflow_cnt;

    int          checks   = 0;
    int          failures = 0;
    int          cycIdx   = 0;
    logic [63:0] loadStart = '0;
    logic [63:0] expQ[$];

    nxs_nonce_reporter dut (
        .clk          (clk),
        .nHashRst     (nHashRst),
        .work_load    (work_load),
        .start_nonce  (start_nonce),
        .issue_nonce  (issue_nonce),
        .hash_qword   (hash_qword),
        .target       (target),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_nonce    (res_nonce),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cycIdx++;
    endtask

    task automatic loadWork(input logic [63:0] s);
        start_nonce = s;
        work_load   = 1'b1;
        tick();
        work_load = 1'b0;
        cycIdx    = 0;
        loadStart = s;
    endtask

    task automatic advanceTo(input int idx);
        while (cycIdx < idx) tick();
    endtask

    // Nonce whose hash appears at hash_qword in the current cycle.
    function automatic logic [63:0] expCand();
        return loadStart + 64'(cycIdx) - 64'(OFF);
    endfunction

    // Hold a hitting qword for n cycles; the first nAcc are expected to be queued.
    task automatic driveHits(input int n, input int nAcc);
        for (int i = 0; i < n; i++) begin
            if (i < nAcc) expQ.push_back(expCand());
            hash_qword = 64'h0;
            tick();
        end
        hash_qword = NOHIT;
    endtask

    task automatic drain(input string tag);
        int budget;
        logic [63:0] e;
        budget    = 0;
        res_ready = 1'b1;
        while (expQ.size() > 0 && budget < 40) begin
            if (res_valid === 1'b1) begin
                e = expQ.pop_front();
                checks++;
                if (res_nonce !== e) begin
                    failures++;
                    $display("FAIL %s_pop got=%h want=%h", tag, res_nonce, e);
                end else begin
                    $display("%s pop nonce=%h", tag, res_nonce);
                end
            end
            tick();
            budget++;
        end
        res_ready = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got=%0d_left want=0_left", tag, expQ.size());
            expQ.delete();
        end
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_empty_after_drain got=%b want=0", tag, res_valid);
        end
    endtask

    task automatic test_reset();
        nHashRst    = 1'b0;
        work_load   = 1'b0;
        res_ready   = 1'b0;
        start_nonce = '0;
        hash_qword  = NOHIT;
        target      = '0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (issue_nonce !== 64'h0) begin failures++; $display("FAIL reset_issue got=%h want=0", issue_nonce); end
        if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", res_valid); end
        if (res_nonce !== 64'h0) begin failures++; $display("FAIL reset_nonce got=%h want=0", res_nonce); end
        if (overflow_cnt !== 8'h0) begin failures++; $display("FAIL reset_ovf got=%0d want=0", overflow_cnt); end
        @(negedge clk);
        nHashRst = 1'b1;
        tick();
        checks++;
        if (issue_nonce !== 64'h1) begin failures++; $display("FAIL reset_first_count got=%h want=1", issue_nonce); end
        $display("reset done issue=%h", issue_nonce);
    endtask

    task automatic test_basic_hit();
        loadWork(64'h0000_0001_FCAF_C044);
        checks++;
        if (issue_nonce !== 64'h0000_0001_FCAF_C044) begin
            failures++; $display("FAIL load_issue got=%h want=%h", issue_nonce, 64'h0000_0001_FCAF_C044);
        end
        advanceTo(OFF + 5);
        checks++;
        if (issue_nonce !== 64'h0000_0001_FCAF_C044 + 64'd395) begin
            failures++; $display("FAIL issue_count got=%h want=%h", issue_nonce, 64'h0000_0001_FCAF_C044 + 64'd395);
        end
        expQ.push_back(64'h0000_0001_FCAF_C049);
        hash_qword = 64'h0000_0000_DEAD_BEEF;
        tick();
        hash_qword = NOHIT;
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL latency_n1 got=%b want=0", res_valid); end
        tick();
        checks++;
        if (res_valid !== 1'b1) begin failures++; $display("FAIL latency_n2 got=%b want=1", res_valid); end
        drain("basic");
    endtask

    task automatic test_warmup();
        loadWork(64'h0000_0000_1234_0000);
        advanceTo(100);
        hash_qword = 64'h0;
        while (cycIdx < OFF) begin
            tick();
            checks++;
            if (res_valid !== 1'b0) begin
                failures++; $display("FAIL warm_valid cyc=%0d got=%b want=0", cycIdx, res_valid);
            end
        end
        hash_qword = NOHIT;
        repeat (3) tick();
        checks += 2;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL warm_late_valid got=%b want=0", res_valid); end
        if (overflow_cnt !== 8'h0) begin failures++; $display("FAIL warm_ovf got=%0d want=0", overflow_cnt); end
        $display("warmup masked, checking first valid slot");
        // Reload so the very first trusted cycle (k=0) can be hit.
        loadWork(64'h0000_0000_1234_0000);
        advanceTo(OFF);
        driveHits(1, 1);
        tick();
        drain("warm_k0");
    endtask

    task automatic test_overflow();
        loadWork(64'h0000_00AB_0000_0100);
        advanceTo(OFF + 2);
        res_ready = 1'b0;
        driveHits(6, 4);
        repeat (3) tick();
        checks += 3;
        if (overflow_cnt !== 8'd2) begin failures++; $display("FAIL ovf_count got=%0d want=2", overflow_cnt); end
        if (res_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b want=1", res_valid); end
        if (res_nonce !== expQ[0]) begin failures++; $display("FAIL ovf_head got=%h want=%h", res_nonce, expQ[0]); end
        drain("ovf");
    endtask

    task automatic test_full_pop_push();
        logic [63:0] c;
        loadWork(64'h0000_0000_0000_7000);
        checks++;
        if (overflow_cnt !== 8'h0) begin failures++; $display("FAIL load_clears_ovf got=%0d want=0", overflow_cnt); end
        advanceTo(OFF + 7);
        res_ready = 1'b0;
        driveHits(4, 4);
        repeat (2) tick();
        c = expCand();
        hash_qword = 64'h0;
        tick();
        hash_qword = NOHIT;
        res_ready  = 1'b1;
        checks++;
        if (res_nonce !== expQ[0]) begin
            failures++; $display("FAIL fullpp_pop got=%h want=%h", res_nonce, expQ[0]);
        end else begin
            $display("fullpp pop nonce=%h with push %h", res_nonce, c);
        end
        void'(expQ.pop_front());
        expQ.push_back(c);
        tick();
        res_ready = 1'b0;
        tick();
        checks += 2;
        if (overflow_cnt !== 8'h0) begin failures++; $display("FAIL fullpp_ovf got=%0d want=0", overflow_cnt); end
        if (res_valid !== 1'b1) begin failures++; $display("FAIL fullpp_valid got=%b want=1", res_valid); end
        drain("fullpp");
    endtask

    task automatic test_wrap_flush();
        loadWork(64'hFFFF_FFFF_FFFF_FFFE);
        advanceTo(OFF + 3);
        checks++;
        if (issue_nonce !== 64'd391) begin failures++; $display("FAIL wrap_issue got=%h want=%h", issue_nonce, 64'd391); end
        hash_qword = 64'h0;
        tick();
        tick();
        hash_qword = NOHIT;
        tick();
        checks += 2;
        if (res_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b want=1", res_valid); end
        if (res_nonce !== 64'h1) begin failures++; $display("FAIL wrap_nonce got=%h want=1", res_nonce); end
        $display("wrap head nonce=%h", res_nonce);
        // New work with two entries queued, a pop request and a hit in the load cycle.
        start_nonce = 64'h0000_0000_0BAD_F00D;
        work_load   = 1'b1;
        res_ready   = 1'b1;
        hash_qword  = 64'h0;
        tick();
        work_load  = 1'b0;
        res_ready  = 1'b0;
        hash_qword = NOHIT;
        cycIdx     = 0;
        loadStart  = 64'h0000_0000_0BAD_F00D;
        checks += 3;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b want=0", res_valid); end
        if (issue_nonce !== 64'h0000_0000_0BAD_F00D) begin failures++; $display("FAIL flush_issue got=%h want=%h", issue_nonce, 64'h0000_0000_0BAD_F00D); end
        if (overflow_cnt !== 8'h0) begin failures++; $display("FAIL flush_ovf got=%0d want=0", overflow_cnt); end
        repeat (3) tick();
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL load_cycle_hit got=%b want=0", res_valid); end
        $display("flush done valid=%b", res_valid);
    endtask

    task automatic test_target();
        loadWork(64'h0000_0010_0000_0000);
        advanceTo(OFF);
        target = 64'h0000_0000_0000_1000;
        expQ.push_back(expCand());
        hash_qword = 64'h0000_0000_0000_0FFF;
        tick();
`ifndef NXS_FULL_TARGET_EN
        expQ.push_back(expCand());
`endif
        hash_qword = 64'h0000_0000_0000_1001;
        tick();
        expQ.push_back(expCand());
        hash_qword = 64'h0000_0000_0000_1000;
        tick();
        hash_qword = NOHIT;
        repeat (2) tick();
        drain("target");
    endtask

    task automatic test_async_reset();
        loadWork(64'h0000_0000_5555_0000);
        advanceTo(OFF);
        res_ready = 1'b0;
        driveHits(6, 0);
        repeat (2) tick();
        checks++;
        if (res_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got=%b want=1", res_valid); end
        #2;
        nHashRst = 1'b0;
        #1;
        checks += 4;
        if (issue_nonce !== 64'h0) begin failures++; $display("FAIL arst_issue got=%h want=0", issue_nonce); end
        if (res_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b want=0", res_valid); end
        if (res_nonce !== 64'h0) begin failures++; $display("FAIL arst_nonce got=%h want=0", res_nonce); end
        if (overflow_cnt !== 8'h0) begin failures++; $display("FAIL arst_ovf got=%0d want=0", overflow_cnt); end
        $display("async reset cleared state");
        @(posedge clk);
        @(negedge clk);
        nHashRst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_warmup();
        test_overflow();
        test_full_pop_push();
        test_wrap_flush();
        test_target();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
